rr_mux_reg: RTL and testbench
=============================

// Module: rr_mux_reg
// PURPOSE
// - Parametrised N-way, WIDTH-bit selector with valid/ready handshake, round-robin arbitration and a registered output.
// - Generalises the fixed 8-way 16-bit selector by choosing the source itself, fairly, rather than taking an external sel.
// - Sits between multiple producers (e.g. memory-mapped peripherals, debug ports) and a single consumer of the CPU data path.
// PARAMETERS
// - WIDTH  16  data width per channel, >= 1
// - N      8   number of input channels, >= 2 (power of 2 not required)
// - SEL_W  $clog2(N)  width of channel index (derived; do not override)
// PORTS
// - clk        in   1        single clock, all state updates on rising edge
// - reset      in   1        synchronous, active-high reset
// - in_valid   in   N        channel i has a word on in_data
// - in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
// - in_ready   out  N        channel i word accepted this cycle (one-hot or zero)
// - out_valid  out  1        out_data holds a valid word
// - out_data   out  WIDTH    registered selected word
// - out_ready  in   1        consumer accepts out_data this cycle
// BEHAVIOUR
// - Reset (sync, active-high): out_valid=0, out_data=0, rr_ptr=0; all in_ready=0 during reset cycle.
// - load_en = !out_valid | out_ready (register empty or being drained this cycle).
// - Grant: first i with in_valid[i]=1 searching rr_ptr, rr_ptr+1, ..., N-1, 0, ..., rr_ptr-1.
// - in_ready[i] = load_en & grant[i]; combinational from in_valid, rr_ptr, out_valid, out_ready.
// - On load (load_en & |in_valid): out_data <= in_data[g], out_valid <= 1, rr_ptr <= (g==N-1) ? 0 : g+1.
// - On drain without load (out_valid & out_ready & !|in_valid): out_valid <= 0; out_data holds last value.
// - Simultaneous drain and load: both happen; full throughput of one word per cycle.
// - Stall (out_valid & !out_ready): out_data, out_valid, rr_ptr stable; all in_ready=0.
// - No requests: rr_ptr unchanged; no grant.
// - Latency: accepted word appears on out_data the following cycle.
// - Fairness: with all channels continuously valid, grants cycle 0,1,...,N-1,0,... with no channel skipped.
// - Wrap: rr_ptr wraps N-1 -> 0 for any N, including non-power-of-2.
// - Reset mid-operation: held word discarded, rr_ptr back to 0; no input accepted in the reset cycle.
// - in_data of non-granted channels ignored; producers must hold in_data/in_valid until in_ready.
// CONFIGURATION
// - Macro RR_MUX_CHAN_ID_EN.
// - Defined: extra port out_chan (out, SEL_W) = index of channel that supplied out_data;
//   loaded with out_data, reset to 0, held during stall/drain.
// - Not defined: port and register absent; all other behaviour identical.
// STRUCTURE
// - Package rr_mux_pkg: localparam-style function clog2 for SEL_W, typedef for channel index.
// - Sub-module rr_grant: combinational N-bit req + SEL_W ptr -> one-hot grant and encoded index.
// - Top: load_en logic, output register, rr_ptr register, flattened in_data slice mux indexed by grant.
// TESTING
// - Reset: assert reset 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0.
// - Single channel: in_valid=8'h10, in_data[4]=16'hBEEF, out_ready=1 -> in_ready=8'h10, next cycle out_data=BEEF, out_valid=1.
// - Fairness: all in_valid=1, channel i data=i, out_ready=1 -> out_data 0,1,...,7,0,1 on consecutive cycles.
// - Backpressure: out_valid=1, out_ready=0 for 5 cycles -> out_data stable, in_ready=0; release -> next word next cycle.
// - Wrap, N=3: requests on 2 then 0,2 -> grants 2 then 0 (ptr 2->0), then 2; with RR_MUX_CHAN_ID_EN out_chan=2,0,2.
// - Reset mid-stall: out_valid=1, out_ready=0, pulse reset -> out_valid=0, rr_ptr=0, next grant from channel 0.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin registered selector.
package rr_mux_pkg;

   localparam int unsigned CHAN_IDX_MAX_W = 16;

   // Wide scratch index used for wrap arithmetic before narrowing to SEL_W.
   typedef logic [CHAN_IDX_MAX_W-1:0] chan_idx_t;

   // Ceiling log2 with a floor of 1 so a channel index is never zero-width.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_mux_reg_grant.sv
// Round-robin priority search: first requester at or after ptr, wrapping at N.
module rr_grant
   import rr_mux_pkg::*;
#(
   parameter int unsigned N     = 8,
   parameter int unsigned SEL_W = clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N-1:0]     grant_c,
   output logic [SEL_W-1:0] idx_c,
   output logic             any_c
);

   chan_idx_t cand;

   always_comb begin
      grant_c = '0;
      idx_c   = '0;
      any_c   = 1'b0;
      cand    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = chan_idx_t'(ptr) + chan_idx_t'(k);
         if (cand >= chan_idx_t'(N)) cand = cand - chan_idx_t'(N);
         if (!any_c && req[SEL_W'(cand)]) begin
            any_c                  = 1'b1;
            grant_c[SEL_W'(cand)]  = 1'b1;
            idx_c                  = SEL_W'(cand);
         end
      end
   end

endmodule

// File: rtl/rr_mux_reg.sv
// N-way round-robin selector with valid/ready handshake and registered output.
// Optional RR_MUX_CHAN_ID_EN adds out_chan, the source index of out_data.
module rr_mux_reg
   import rr_mux_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned N     = 8,
   parameter int unsigned SEL_W = clog2(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   input  logic               out_ready
`ifdef RR_MUX_CHAN_ID_EN
   ,output logic [SEL_W-1:0]  out_chan
`endif
);

   logic [N-1:0]     grant_c;
   logic [SEL_W-1:0] grant_idx_c;
   logic             grant_any_c;
   logic             load_en_c;
   logic             load_c;
   logic [WIDTH-1:0] sel_data_c;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;
`ifdef RR_MUX_CHAN_ID_EN
   logic [SEL_W-1:0] out_chan_q,  out_chan_d;
`endif

   rr_grant #(.N(N), .SEL_W(SEL_W)) u_grant (
      .req     (in_valid),
      .ptr     (rr_ptr_q),
      .grant_c (grant_c),
      .idx_c   (grant_idx_c),
      .any_c   (grant_any_c)
   );

   // Handshake and one-hot AND-OR data select; nothing is accepted while in reset.
   always_comb begin
      load_en_c  = ~out_valid_q | out_ready;
      load_c     = load_en_c & grant_any_c & ~reset;
      in_ready   = (load_en_c & ~reset) ? grant_c : '0;
      sel_data_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant_c[i]) sel_data_c = sel_data_c | in_data[i*WIDTH +: WIDTH];
      end
   end

   // Load takes priority over drain so back-to-back words flow at full rate.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      rr_ptr_d    = rr_ptr_q;
`ifdef RR_MUX_CHAN_ID_EN
      out_chan_d  = out_chan_q;
`endif
      if (load_c) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data_c;
         rr_ptr_d    = (grant_idx_c == SEL_W'(N-1)) ? '0 : grant_idx_c + SEL_W'(1);
`ifdef RR_MUX_CHAN_ID_EN
         out_chan_d  = grant_idx_c;
`endif
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         rr_ptr_q    <= '0;
`ifdef RR_MUX_CHAN_ID_EN
         out_chan_q  <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         rr_ptr_q    <= rr_ptr_d;
`ifdef RR_MUX_CHAN_ID_EN
         out_chan_q  <= out_chan_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
`ifdef RR_MUX_CHAN_ID_EN
   assign out_chan  = out_chan_q;
`endif

endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: directed cases plus random traffic against a queue-free behavioural model.
module tb_rr_mux_reg;

   localparam int unsigned N8 = 8;
   localparam int unsigned W8 = 16;
   localparam int unsigned N3 = 3;
   localparam int unsigned W3 = 8;

   logic              clk;
   logic              reset;
   logic [N8-1:0]     in_valid;
   logic [N8*W8-1:0]  in_data;
   logic [N8-1:0]     in_ready;
   logic              out_valid;
   logic [W8-1:0]     out_data;
   logic              out_ready;

   logic              reset3;
   logic [N3-1:0]     in_valid3;
   logic [N3*W3-1:0]  in_data3;
   logic [N3-1:0]     in_ready3;
   logic              out_valid3;
   logic [W3-1:0]     out_data3;
   logic              out_ready3;

`ifdef RR_MUX_CHAN_ID_EN
   logic [2:0]        out_chan;
   logic [1:0]        out_chan3;
   int                m_chan;
`endif

   int                checks;
   int                fails;
   logic              chk_en;

   // Model state: what the output register and pointer must hold.
   int                m_ptr;
   logic              m_valid;
   logic [W8-1:0]     m_data;

   rr_mux_reg #(.WIDTH(W8), .N(N8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
`ifdef RR_MUX_CHAN_ID_EN
      ,.out_chan (out_chan)
`endif
   );

   rr_mux_reg #(.WIDTH(W3), .N(N3)) dut3 (
      .clk       (clk),
      .reset     (reset3),
      .in_valid  (in_valid3),
      .in_data   (in_data3),
      .in_ready  (in_ready3),
      .out_valid (out_valid3),
      .out_data  (out_data3),
      .out_ready (out_ready3)
`ifdef RR_MUX_CHAN_ID_EN
      ,.out_chan (out_chan3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Falling-edge sample: compare DUT to model, then advance the model across the next rising edge.
   task automatic half();
      int g;
      logic [N8-1:0] er;
      @(negedge clk);
      g  = -1;
      er = '0;
      if (!reset && (!m_valid || out_ready)) begin
         for (int k = 0; k < int'(N8); k++) begin
            int c;
            c = (m_ptr + k) % int'(N8);
            if (g < 0 && in_valid[c]) g = c;
         end
      end
      if (g >= 0) er[g] = 1'b1;
      if (chk_en) begin
         check("model_in_ready", 32'(in_ready), 32'(er));
         check("model_out_valid", 32'(out_valid), 32'(m_valid));
         check("model_out_data", 32'(out_data), 32'(m_data));
`ifdef RR_MUX_CHAN_ID_EN
         check("model_out_chan", 32'(out_chan), 32'(m_chan));
`endif
      end
      if (reset) begin
         m_ptr   = 0;
         m_valid = 1'b0;
         m_data  = '0;
`ifdef RR_MUX_CHAN_ID_EN
         m_chan  = 0;
`endif
      end else if (g >= 0) begin
         m_data  = in_data[g*W8 +: W8];
         m_valid = 1'b1;
         m_ptr   = (g + 1) % int'(N8);
`ifdef RR_MUX_CHAN_ID_EN
         m_chan  = g;
`endif
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic load_index_data();
      for (int i = 0; i < int'(N8); i++) in_data[i*W8 +: W8] = 16'(i);
   endtask

   initial begin
      logic [N8-1:0] acc;
      checks = 0;
      fails  = 0;
      chk_en = 1'b0;
      m_ptr  = 0;
      m_valid = 1'b0;
      m_data = '0;
`ifdef RR_MUX_CHAN_ID_EN
      m_chan = 0;
`endif
      reset      = 1'b1;
      in_valid   = '1;
      in_data    = '0;
      load_index_data();
      out_ready  = 1'b0;
      reset3     = 1'b1;
      in_valid3  = '0;
      in_data3   = {8'hA2, 8'hA1, 8'hA0};
      out_ready3 = 1'b0;

      // Reset held two cycles with every channel requesting
      half();
      chk_en = 1'b1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      adv();
      half();
      check("rst2_in_ready", 32'(in_ready), 32'd0);
      check("rst2_out_valid", 32'(out_valid), 32'd0);

      // Single requester on channel 4
      adv();
      reset     = 1'b0;
      in_valid  = 8'h10;
      in_data   = '0;
      in_data[4*W8 +: W8] = 16'hBEEF;
      out_ready = 1'b1;
      half();
      check("single_in_ready", 32'(in_ready), 32'h10);
      adv();
      in_valid = '0;
      check("single_out_valid", 32'(out_valid), 32'd1);
      check("single_out_data", 32'(out_data), 32'hBEEF);
      half();

      // Fairness with all channels valid from pointer 0
      adv();
      reset = 1'b1;
      half();
      adv();
      reset    = 1'b0;
      in_valid = '1;
      load_index_data();
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         half();
         check("fair_grant", 32'(in_ready), 32'd1 << (k % 8));
         adv();
         check("fair_data", 32'(out_data), 32'(k % 8));
      end

      // Backpressure: word 1 held, nothing accepted, then channel 2 next
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         half();
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_data", 32'(out_data), 32'd1);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         adv();
      end
      out_ready = 1'b1;
      half();
      check("release_grant", 32'(in_ready), 32'h04);
      adv();
      check("release_data", 32'(out_data), 32'd2);

      // Reset during a stall discards the word and restarts at channel 0
      out_ready = 1'b0;
      half();
      adv();
      reset = 1'b1;
      half();
      check("rststall_in_ready", 32'(in_ready), 32'd0);
      adv();
      reset     = 1'b0;
      out_ready = 1'b1;
      check("rststall_out_valid", 32'(out_valid), 32'd0);
      half();
      check("rststall_grant", 32'(in_ready), 32'h01);
      adv();
      check("rststall_data", 32'(out_data), 32'd0);

      // Wrap on a three-channel instance
      in_valid = '0;
      half();
      adv();
      reset3 = 1'b0;
      in_valid3  = 3'b100;
      out_ready3 = 1'b1;
      half();
      check("wrap_grant_a", 32'(in_ready3), 32'h4);
      adv();
      check("wrap_data_a", 32'(out_data3), 32'hA2);
`ifdef RR_MUX_CHAN_ID_EN
      check("wrap_chan_a", 32'(out_chan3), 32'd2);
`endif
      in_valid3 = 3'b101;
      half();
      check("wrap_grant_b", 32'(in_ready3), 32'h1);
      adv();
      check("wrap_data_b", 32'(out_data3), 32'hA0);
`ifdef RR_MUX_CHAN_ID_EN
      check("wrap_chan_b", 32'(out_chan3), 32'd0);
`endif
      in_valid3 = 3'b100;
      half();
      check("wrap_grant_c", 32'(in_ready3), 32'h4);
      adv();
      check("wrap_data_c", 32'(out_data3), 32'hA2);
      check("wrap_valid_c", 32'(out_valid3), 32'd1);
`ifdef RR_MUX_CHAN_ID_EN
      check("wrap_chan_c", 32'(out_chan3), 32'd2);
`endif
      in_valid3 = '0;

      // Random traffic; producers hold their word until it is accepted
      for (int n = 0; n < 4000; n++) begin
         half();
         acc = in_ready;
         adv();
         for (int i = 0; i < int'(N8); i++) begin
            if (!(in_valid[i] && !acc[i])) begin
               in_valid[i] = ($urandom % 3) != 0;
               in_data[i*W8 +: W8] = 16'($urandom);
            end
         end
         out_ready = ($urandom % 4) != 0;
         reset     = ($urandom % 200) == 0;
      end
      reset = 1'b0;
      half();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
